sequence_generator: RTL and testbench
=====================================

# sequence_generator

Serial pattern transmitter that drives the bit stream consumed by `sequence_detector`. It loads a parallel pattern and a length, then emits the bits MSB-first, one per clock, with an optional repeat count and a start/busy/done handshake. It sits upstream of the detector's `x_i` input, and its `x_o` can be looped straight into that input for self-checking benches.

## Interface
- `PAT_W`, 36: maximum pattern width in bits.
- `CNT_W`, `$clog2(PAT_W+1)`: width of the length field.
- `REP_W`, 4: width of the repeat field.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request to transmit; sampled only in IDLE.
- `pattern_i`  in  PAT_W  pattern; bits `[len-1:0]` are transmitted.
- `len_i`  in  CNT_W  bits per repetition; 0 or values > PAT_W mean PAT_W.
- `repeat_i`  in  REP_W  extra repetitions; total passes = `repeat_i+1`.
- `abort_i`  in  1  synchronous abort of the current transfer.
- `x_o`  out  1  serial data bit.
- `valid_o`  out  1  `x_o` carries a pattern bit this cycle.
- `busy_o`  out  1  transfer in progress; `start_i` is ignored.
- `done_o`  out  1  one-cycle pulse after the last bit of the last pass.

## Operation
- **States:** IDLE and SEND.
- **IDLE:**
  - `x_o`=0, `valid_o`=0, `busy_o`=0.
  - When `start_i`=1, latch `pattern_i`, the effective length L and the pass count R=`repeat_i+1`; load the shift register; go to SEND.
- **SEND:**
  - `valid_o`=1, `busy_o`=1.
  - `x_o` = the current bit of the latched pattern, index L-1 down to 0.
  - The bit counter decrements each cycle.
  - At index 0 with passes remaining, reload from the latched pattern. The next pass starts with no gap cycle.
  - At index 0 on the last pass, go to IDLE and pulse `done_o`.
- **Abort:** `abort_i`=1 in SEND goes to IDLE at the next edge. No `done_o` is produced. `abort_i` in IDLE has no effect.
- **Start while busy:** `start_i` during SEND is ignored; it is not queued.
- **Length clamping:**
  - An L=0 request sends PAT_W bits.
  - An L>PAT_W request sends PAT_W bits.
  - L=1 sends only `pattern_i[0]`.
- **Width rules:** the pass counter is REP_W+1 bits wide, so `repeat_i` = all-ones gives 2^REP_W passes with no wrap.
- **Input isolation:** changes on `pattern_i`, `len_i` or `repeat_i` after the start edge do not affect the transfer in flight.
- **Reset:** all outputs are registered and reset to 0, state to IDLE and counters to 0. Reset mid-transfer takes effect at the next edge and drops `valid_o` with no `done_o`. Reset has priority over `abort_i` and `start_i`.

## Timing
- **Start latency:** `start_i` sampled at edge n gives the first bit on `x_o` with `valid_o`=1 in the cycle after edge n.
- **Transfer length:** bits occupy L×R consecutive cycles.
- **Done timing:** `done_o`=1 for exactly one cycle, the first IDLE cycle. `busy_o`=0 in that cycle, and a `start_i` in that cycle is accepted.
- **Abort timing:** `abort_i` at edge m means `valid_o`=0 from the cycle after edge m.
- **Throughput:** with back-to-back starts there is one idle cycle (the done cycle) between transfers.
- **Output stability:** `x_o` changes only on the rising edge of `clk`. This keeps it stable for a consumer that samples on the following edge.

## Structure
- **Package `seq_gen_pkg`:**
  - `typedef enum logic {IDLE, SEND} seq_gen_state_t;`
  - Default constants PAT_W=36 and REP_W=4.
  - Reference pattern constant `SEQ_PAT = 36'hEDB_EDB_EDB` (`1110_1101_1011` repeated three times).
- **Sub-module `piso_shift`:** a parameterised parallel-in serial-out register with `load`, `shift` and `msb_o`. The pattern is left-justified on load so that bit L-1 is at the MSB.
- **Top module:** holds the FSM, the bit counter and the pass counter.

## Test plan
- **Basic transfer:**
  - Stimulus: `pattern_i`=36'hEDBEDBEDB, `len_i`=36, `repeat_i`=0, one-cycle `start_i`.
  - Response: 36 bits `1110_1101_1011`×3 MSB-first, `valid_o` high for exactly 36 cycles, then `done_o` for one cycle.
- **Repeat with short length:**
  - Stimulus: `len_i`=4, `pattern_i`=4'b1011, `repeat_i`=2.
  - Response: `101110111011` over 12 contiguous valid cycles, then a single `done_o`.
- **Length clamping:**
  - Stimulus: `len_i`=0; then `len_i`=63.
  - Response: both send 36 bits. Separately, `len_i`=1 with `pattern_i[0]`=1 sends a single valid `1`.
- **Abort and ignored start:**
  - Stimulus: `start_i` pulsed at bit 5 of a 36-bit transfer; then `abort_i` at bit 10.
  - Response: the start pulse has no effect. After the abort, `valid_o`=0 and `busy_o`=0 from the next cycle, with no `done_o`.
- **Reset and restart:**
  - Stimulus: `reset` mid-transfer.
  - Response: all outputs 0 after the next edge. A new start then works normally.
  - Stimulus: `start_i` held high.
  - Response: transfers re-launch from each done cycle.
- **Loopback to detector:**
  - Stimulus: `x_o` wired to `sequence_detector.x_i` with `SEQ_PAT`.
  - Response: detector `det_o` pulses match the detector's golden pattern positions.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
// SEQ_PAT is the reference pattern that the downstream sequence detector looks for.
package seq_gen_pkg;

  localparam int PAT_W_DEFAULT = 36;
  localparam int REP_W_DEFAULT = 4;

  localparam logic [35:0] SEQ_PAT = 36'hEDB_EDB_EDB;

  typedef enum logic {IDLE, SEND} seq_gen_state_t;

endpackage

// File: rtl/sequence_generator_piso_shift.sv
// Parallel-in serial-out shift register.
// On load the pattern is shifted left by lsh_i, so that its top pattern bit lands on the MSB.
module piso_shift #(
  parameter int W    = 36,
  parameter int SH_W = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic            clear_i,
  input  logic [W-1:0]    data_i,
  input  logic [SH_W-1:0] lsh_i,
  output logic            msb_o
);

  logic [W-1:0] shiftReg_q, shiftReg_d;

  // Clear takes priority so that x_o reads 0 as soon as a transfer ends or is aborted.
  always_comb begin
    shiftReg_d = shiftReg_q;
    if (clear_i) begin
      shiftReg_d = '0;
    end else if (load_i) begin
      shiftReg_d = data_i << lsh_i;
    end else if (shift_i) begin
      shiftReg_d = {shiftReg_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg_q <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
    end
  end

  assign msb_o = shiftReg_q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends pattern bits [L-1:0] MSB-first for repeat_i+1 passes,
// with a start/busy/done handshake and a synchronous abort.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = $clog2(PAT_W + 1),
  parameter int REP_W = REP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [REP_W-1:0] repeat_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(PAT_W);

  seq_gen_state_t   state_q, state_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [REP_W:0]   passCnt_q, passCnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] effLen;
  logic [PAT_W-1:0] loadPat;
  logic [CNT_W-1:0] loadLen;
  logic             loadSr, shiftSr, clearSr;

  assign effLen = ((len_i == '0) || (len_i > FULL_LEN)) ? FULL_LEN : len_i;

  // Next-state logic; the pass counter has one spare bit so repeat_i all-ones cannot wrap.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    passCnt_d = passCnt_q;
    len_d     = len_q;
    pat_d     = pat_q;
    done_d    = 1'b0;
    loadSr    = 1'b0;
    shiftSr   = 1'b0;
    clearSr   = 1'b0;
    loadPat   = pat_q;
    loadLen   = len_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = SEND;
          pat_d     = pattern_i;
          len_d     = effLen;
          bitCnt_d  = effLen - CNT_W'(1);
          passCnt_d = {1'b0, repeat_i} + (REP_W + 1)'(1);
          loadSr    = 1'b1;
          loadPat   = pattern_i;
          loadLen   = effLen;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_d   = IDLE;
          bitCnt_d  = '0;
          passCnt_d = '0;
          clearSr   = 1'b1;
        end else if (bitCnt_q == '0) begin
          if (passCnt_q > (REP_W + 1)'(1)) begin
            passCnt_d = passCnt_q - (REP_W + 1)'(1);
            bitCnt_d  = len_q - CNT_W'(1);
            loadSr    = 1'b1;
          end else begin
            state_d   = IDLE;
            passCnt_d = '0;
            done_d    = 1'b1;
            clearSr   = 1'b1;
          end
        end else begin
          bitCnt_d = bitCnt_q - CNT_W'(1);
          shiftSr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      passCnt_q <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      passCnt_q <= passCnt_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      done_q    <= done_d;
    end
  end

  piso_shift #(
    .W    (PAT_W),
    .SH_W (CNT_W)
  ) uShift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (loadSr),
    .shift_i (shiftSr),
    .clear_i (clearSr),
    .data_i  (loadPat),
    .lsh_i   (FULL_LEN - loadLen),
    .msb_o   (x_o)
  );

  assign valid_o = (state_q == SEND);
  assign busy_o  = (state_q == SEND);
  assign done_o  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: a queue-based model of the expected bit stream
// is compared against the DUT every cycle, plus literal checks of whole captured transfers.
module tb_sequence_generator;
  import seq_gen_pkg::*;

  localparam int PAT_W = 36;
  localparam int CNT_W = 6;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_i = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic [CNT_W-1:0] len_i = '0;
  logic [REP_W-1:0] repeat_i = '0;
  logic             abort_i = 1'b0;
  logic             x_o, valid_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  bit expQ[$];
  bit expDone = 1'b0;
  bit modelLive = 1'b0;

  logic [63:0] curStream = '0;
  int          curCnt = 0;
  logic [63:0] lastStream = '0;
  int          lastCnt = 0;
  bit          prevValid = 1'b0;
  int          doneCount = 0;

  sequence_generator #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .REP_W (REP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .pattern_i (pattern_i),
    .len_i     (len_i),
    .repeat_i  (repeat_i),
    .abort_i   (abort_i),
    .x_o       (x_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transfer is simply the list of bits it must put on the wire.
  always @(posedge clk) begin
    modelLive <= 1'b1;
    if (reset) begin
      expQ.delete();
      expDone = 1'b0;
    end else if (expQ.size() != 0) begin
      if (abort_i) begin
        expQ.delete();
        expDone = 1'b0;
      end else begin
        void'(expQ.pop_front());
        expDone = (expQ.size() == 0);
      end
    end else begin
      expDone = 1'b0;
      if (start_i) begin
        int L;
        int passes;
        L = (len_i == 0 || int'(len_i) > PAT_W) ? PAT_W : int'(len_i);
        passes = int'(repeat_i) + 1;
        for (int r = 0; r < passes; r++)
          for (int i = L - 1; i >= 0; i--)
            expQ.push_back(pattern_i[i]);
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("valid_o", {63'd0, valid_o}, {63'd0, expQ.size() != 0});
      checkOutput("busy_o", {63'd0, busy_o}, {63'd0, expQ.size() != 0});
      checkOutput("x_o", {63'd0, x_o}, {63'd0, (expQ.size() != 0) ? expQ[0] : 1'b0});
      checkOutput("done_o", {63'd0, done_o}, {63'd0, expDone});
    end
  end

  // Collects the DUT's serial stream so whole transfers can be checked against literals.
  always @(negedge clk) begin
    if (valid_o && !prevValid) begin
      curStream = '0;
      curCnt = 0;
    end
    if (valid_o) begin
      curStream = {curStream[62:0], x_o};
      curCnt++;
    end
    if (done_o) begin
      lastStream = curStream;
      lastCnt = curCnt;
      doneCount++;
    end
    prevValid = valid_o;
  end

  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] len,
                               input logic [REP_W-1:0] rep);
    pattern_i = pat;
    len_i     = len;
    repeat_i  = rep;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s: timeout waiting for idle after %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runTransfer(input string name, input logic [PAT_W-1:0] pat,
                             input logic [CNT_W-1:0] len, input logic [REP_W-1:0] rep,
                             input int expCnt, input logic [63:0] expStream);
    int d0;
    d0 = doneCount;
    applyStimulus(pat, len, rep);
    waitIdle(name, 700);
    checkOutput({name, "_count"}, 64'(lastCnt), 64'(expCnt));
    checkOutput({name, "_stream"}, lastStream, expStream);
    checkOutput({name, "_dones"}, 64'(doneCount - d0), 64'd1);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_outputs", {60'd0, x_o, valid_o, busy_o, done_o}, 64'd0);

    runTransfer("basic", SEQ_PAT, 6'd36, 4'd0, 36, 64'hEDBEDBEDB);
    runTransfer("repeat4", 36'hABCDE123B, 6'd4, 4'd2, 12, 64'hBBB);
    runTransfer("len0", 36'h123456789, 6'd0, 4'd0, 36, 64'h123456789);
    runTransfer("len63", 36'h9ABCDEF01, 6'd63, 4'd0, 36, 64'h9ABCDEF01);
    runTransfer("len1", 36'hFFFFFFFF1, 6'd1, 4'd0, 1, 64'h1);
    runTransfer("maxrep", 36'h000000002, 6'd2, 4'd15, 32, 64'hAAAAAAAA);

    // Start pulse at bit 5 is ignored; abort at bit 10 ends the transfer without done.
    d0 = doneCount;
    applyStimulus(SEQ_PAT, 6'd36, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    pattern_i = 36'h0F0F0F0F0;
    len_i = 6'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    checkOutput("abort_outputs", {60'd0, x_o, valid_o, busy_o, done_o}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 64'(doneCount - d0), 64'd0);

    // Reset mid-transfer, then a normal restart.
    d0 = doneCount;
    applyStimulus(SEQ_PAT, 6'd36, 4'd1);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    checkOutput("reset_mid_outputs", {60'd0, x_o, valid_o, busy_o, done_o}, 64'd0);
    checkOutput("reset_mid_no_done", 64'(doneCount - d0), 64'd0);
    runTransfer("restart", 36'h00000005A, 6'd8, 4'd0, 8, 64'h5A);

    // Start held high relaunches from each done cycle.
    d0 = doneCount;
    pattern_i = 36'h5;
    len_i = 6'd3;
    repeat_i = 4'd0;
    start_i = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    start_i = 1'b0;
    waitIdle("held_start", 50);
    checkOutput("held_start_dones", 64'(doneCount - d0), 64'd4);

    // Randomized phase: inputs change freely mid-flight to exercise isolation.
    for (int c = 0; c < 3000; c++) begin
      pattern_i = {$urandom, $urandom} & {PAT_W{1'b1}};
      len_i     = CNT_W'($urandom_range(0, 63));
      repeat_i  = REP_W'($urandom_range(0, 15));
      start_i   = ($urandom_range(0, 3) == 0);
      abort_i   = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    reset = 1'b0;
    waitIdle("random_drain", 700);

    $display("[TB] %0d/%0d checks passed", checks - errors, checks);
    $finish;
  end

endmodule
